// File: rtl/softmax_stream.sv
// rtl/softmax_stream.sv - streaming base-2 softmax with max subtraction and a restoring divider
module softmax_stream #(
  parameter int N      = 10,
  parameter int DATA_W = 8,
  parameter int EXP_W  = 16,
  parameter int OUT_W  = 8,
  parameter int SUM_W  = EXP_W + $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_data,
  output logic              out_last,
  output logic              busy
);

  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int BUF_W = (DATA_W > EXP_W) ? DATA_W : EXP_W;
  localparam int NUM_W = EXP_W + OUT_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(OUT_W - 1);
  localparam logic [EXP_W-1:0] E_MAX    = '1;

  typedef enum logic [1:0] {LOAD, EXP, DIV, OUT} state_t;
  state_t state, state_nxt;

  // Slot i holds the logit during LOAD/EXP and its exponential afterwards.
  logic [BUF_W-1:0] buffer [N];

  logic [IDX_W-1:0]         k;
  logic [IDX_W-1:0]         i;
  logic signed [DATA_W-1:0] m;
  logic [SUM_W-1:0]         sum;
  logic [SUM_W-1:0]         rem;
  logic [OUT_W-1:0]         num_lo;
  logic [OUT_W-1:0]         q;
  logic [CNT_W-1:0]         div_cnt;

  logic signed [DATA_W-1:0] x_in;
  logic signed [DATA_W-1:0] x_cur;
  logic [DATA_W:0]          d;
  logic [EXP_W-1:0]         e_cur;
  logic [IDX_W-1:0]         pre_idx;
  logic [EXP_W-1:0]         pre_e;
  logic [NUM_W-1:0]         pre_num;
  logic [SUM_W:0]           trial;
  logic                     trial_ge;
  logic                     in_fire;

  // Exponential of the current element and divider operand preparation.
  always_comb begin
    x_in     = signed'(in_data);
    x_cur    = signed'(buffer[i][DATA_W-1:0]);
    d        = {m[DATA_W-1], m} - {x_cur[DATA_W-1], x_cur};
    e_cur    = '0;
    if (32'(d) < 32'(EXP_W)) begin
      e_cur = E_MAX >> d;
    end
    // Next element to divide: slot 0 when leaving EXP, else the one after i.
    pre_idx  = (state == EXP || i == LAST_IDX) ? '0 : i + 1'b1;
    pre_e    = buffer[pre_idx][EXP_W-1:0];
    // e * (2^OUT_W - 1); the top EXP_W bits are already below S, so they seed
    // the remainder and only the low OUT_W bits need shifting in.
    pre_num  = {pre_e, {OUT_W{1'b0}}} - NUM_W'(pre_e);
    trial    = {rem, num_lo[OUT_W-1]};
    trial_ge = (trial >= {1'b0, sum});
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    busy      = 1'b1;
    case (state)
      LOAD: begin
        in_ready = 1'b1;
        busy     = (k != '0);
        if (in_valid && k == LAST_IDX) state_nxt = EXP;
      end
      EXP: begin
        if (i == LAST_IDX) state_nxt = DIV;
      end
      DIV: begin
        if (div_cnt == LAST_BIT) state_nxt = OUT;
      end
      OUT: begin
        out_valid = 1'b1;
        out_data  = q;
        out_last  = (i == LAST_IDX);
        if (out_ready) state_nxt = (i == LAST_IDX) ? LOAD : DIV;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign in_fire = in_valid && in_ready;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= LOAD;
    else        state <= state_nxt;
  end

  // Element buffer: logits written in LOAD, replaced by exponentials in EXP.
  always_ff @(posedge clk) begin
    if (state == LOAD && in_valid) buffer[k] <= BUF_W'(in_data);
    else if (state == EXP)         buffer[i] <= BUF_W'(e_cur);
  end

  // Counters, running max, accumulator and bit-serial divider.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k       <= '0;
      i       <= '0;
      m       <= '0;
      sum     <= '0;
      rem     <= '0;
      num_lo  <= '0;
      q       <= '0;
      div_cnt <= '0;
    end else begin
      case (state)
        LOAD: begin
          if (in_fire) begin
            if (k == '0 || x_in > m) m <= x_in;
            if (k != LAST_IDX) k <= k + 1'b1;
          end
        end
        EXP: begin
          sum <= sum + SUM_W'(e_cur);
          if (i == LAST_IDX) begin
            i       <= '0;
            rem     <= SUM_W'(pre_num[NUM_W-1:OUT_W]);
            num_lo  <= pre_num[OUT_W-1:0];
            div_cnt <= '0;
          end else begin
            i <= i + 1'b1;
          end
        end
        DIV: begin
          // The remainder stays below S, so the low SUM_W bits are exact.
          rem     <= trial_ge ? (trial[SUM_W-1:0] - sum) : trial[SUM_W-1:0];
          q       <= {q[OUT_W-2:0], trial_ge};
          num_lo  <= {num_lo[OUT_W-2:0], 1'b0};
          div_cnt <= (div_cnt == LAST_BIT) ? '0 : div_cnt + 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            if (i == LAST_IDX) begin
              i   <= '0;
              k   <= '0;
              m   <= '0;
              sum <= '0;
            end else begin
              i       <= i + 1'b1;
              rem     <= SUM_W'(pre_num[NUM_W-1:OUT_W]);
              num_lo  <= pre_num[OUT_W-1:0];
              div_cnt <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_softmax_stream.sv
// tb/tb_softmax_stream.sv - scoreboard bench for softmax_stream (N=4 directed, N=10 random)
`timescale 1ns/1ps
module tb_softmax_stream;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid  [2];
  logic       in_ready  [2];
  logic [7:0] in_data   [2];
  logic       out_valid [2];
  logic       out_ready [2];
  logic [7:0] out_data  [2];
  logic       out_last  [2];
  logic       busy      [2];

  int         cyc = 0;
  int         n_checks = 0;
  int         n_fail = 0;
  logic [8:0] sb0 [$];
  logic [8:0] sb1 [$];
  int         vec  [10];
  int         expv [10];
  int         t_last;

  softmax_stream #(.N(4), .DATA_W(8), .EXP_W(8), .OUT_W(8)) dut4 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[0]), .in_ready(in_ready[0]), .in_data(in_data[0]),
    .out_valid(out_valid[0]), .out_ready(out_ready[0]), .out_data(out_data[0]),
    .out_last(out_last[0]), .busy(busy[0])
  );

  softmax_stream dut10 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid[1]), .in_ready(in_ready[1]), .in_data(in_data[1]),
    .out_valid(out_valid[1]), .out_ready(out_ready[1]), .out_data(out_data[1]),
    .out_last(out_last[1]), .busy(busy[1])
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input longint got, input longint want);
    n_checks++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, got, want);
    end
  endtask

  // Monitor: pop and compare on every output handshake.
  always @(negedge clk) begin
    logic [8:0] ex;
    bit         have;
    for (int dd = 0; dd < 2; dd++) begin
      if (rst_n && out_valid[dd] && out_ready[dd]) begin
        have = 1'b0;
        ex   = '0;
        if (dd == 0 && sb0.size() > 0) begin ex = sb0.pop_front(); have = 1'b1; end
        if (dd == 1 && sb1.size() > 0) begin ex = sb1.pop_front(); have = 1'b1; end
        n_checks++;
        if (!have) begin
          n_fail++;
          $display("FAIL sb%0d_extra: got data=%0d last=%0d, expected no output", dd, out_data[dd], out_last[dd]);
        end else if ({out_last[dd], out_data[dd]} != ex) begin
          n_fail++;
          $display("FAIL sb%0d_out: got data=%0d last=%0d, expected data=%0d last=%0d",
                   dd, out_data[dd], out_last[dd], ex[7:0], ex[8]);
        end
      end
    end
  end

  task automatic push(input int d, input int n);
    for (int j = 0; j < n; j++) begin
      if (d == 0) sb0.push_back({(j == n - 1), expv[j][7:0]});
      else        sb1.push_back({(j == n - 1), expv[j][7:0]});
    end
  endtask

  task automatic load4(input int a0, input int a1, input int a2, input int a3,
                       input int e0, input int e1, input int e2, input int e3);
    vec[0] = a0; vec[1] = a1; vec[2] = a2; vec[3] = a3;
    expv[0] = e0; expv[1] = e1; expv[2] = e2; expv[3] = e3;
    push(0, 4);
  endtask

  function automatic void model10();
    int     mx;
    int     dd;
    longint s;
    longint e [10];
    mx = vec[0];
    for (int j = 1; j < 10; j++) if (vec[j] > mx) mx = vec[j];
    s = 0;
    for (int j = 0; j < 10; j++) begin
      dd   = mx - vec[j];
      e[j] = (dd >= 16) ? 64'sd0 : (longint'(65535) >> dd);
      s    = s + e[j];
    end
    for (int j = 0; j < 10; j++) expv[j] = int'((e[j] * 255) / s);
  endfunction

  // Called at posedge+1; returns at posedge+1 after the last element is taken.
  task automatic send(input int d, input int n, output int tl);
    int w;
    tl = 0;
    for (int j = 0; j < n; j++) begin
      in_valid[d] = 1'b1;
      in_data[d]  = vec[j][7:0];
      w = 0;
      do begin
        @(negedge clk);
        w++;
        if (j == 0 && w == 1) begin
          check($sformatf("idle_in_ready_%0d", d), in_ready[d], 1);
          check($sformatf("idle_busy_%0d", d), busy[d], 0);
        end
      end while (!in_ready[d] && w < 50);
      if (!in_ready[d]) check($sformatf("send_timeout_%0d", d), in_ready[d], 1);
      tl = cyc;
      @(posedge clk); #1;
    end
    in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int tl, input bit chk_lat);
    bit seen;
    bit ir_bad;
    int w;
    seen = 1'b0; ir_bad = 1'b0; w = 0;
    do begin
      @(negedge clk);
      w++;
      if (in_ready[d]) ir_bad = 1'b1;
      if (!seen && out_valid[d]) begin
        seen = 1'b1;
        if (chk_lat) check("first_out_latency", cyc - tl, 13);
      end
    end while (!(out_valid[d] && out_ready[d] && out_last[d]) && w < 600);
    check($sformatf("frame_done_%0d", d), out_valid[d] && out_ready[d] && out_last[d], 1);
    check($sformatf("in_ready_low_%0d", d), ir_bad, 0);
    @(posedge clk); #1;
  endtask

  // Stall element 1 of a 3,2,1,0 frame for five cycles.
  task automatic backpressure();
    int w;
    int h;
    w = 0;
    do begin @(negedge clk); w++; end while (!(out_valid[0] && out_ready[0]) && w < 100);
    h = cyc;
    @(posedge clk); #1;
    out_ready[0] = 1'b0;
    w = 0;
    do begin @(negedge clk); w++; end while (!out_valid[0] && w < 100);
    check("elem1_latency", cyc - h, 9);
    for (int r = 0; r < 5; r++) begin
      if (r > 0) @(negedge clk);
      check("hold_valid", out_valid[0], 1);
      check("hold_data", out_data[0], 68);
      check("hold_last", out_last[0], 0);
    end
    @(posedge clk); #1;
    out_ready[0] = 1'b1;
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      in_valid[d]  = 1'b0;
      in_data[d]   = '0;
      out_ready[d] = 1'b1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready[0], 1);
    check("rst_out_valid", out_valid[0], 0);
    check("rst_out_data", out_data[0], 0);
    check("rst_out_last", out_last[0], 0);
    check("rst_busy", busy[0], 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    load4(5, 5, 5, 5, 63, 63, 63, 63);
    send(0, 4, t_last);
    wait_done(0, t_last, 1'b1);

    load4(3, 2, 1, 0, 136, 68, 33, 16);
    send(0, 4, t_last);
    fork
      wait_done(0, t_last, 1'b0);
      backpressure();
    join

    load4(-128, 127, -128, -128, 0, 255, 0, 0);
    send(0, 4, t_last);
    wait_done(0, t_last, 1'b1);

    load4(0, 0, 0, 7, 0, 0, 0, 252);
    send(0, 4, t_last);
    wait_done(0, t_last, 1'b1);

    load4(3, 2, 1, 0, 136, 68, 33, 16);
    send(0, 4, t_last);
    repeat (6) @(posedge clk);
    #1;
    rst_n = 1'b0;
    sb0.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", out_valid[0], 0);
    check("midrst_in_ready", in_ready[0], 1);
    check("midrst_busy", busy[0], 0);
    @(posedge clk); #1;

    load4(5, 5, 5, 5, 63, 63, 63, 63);
    send(0, 4, t_last);
    wait_done(0, t_last, 1'b1);

    for (int f = 0; f < 3; f++) begin
      for (int j = 0; j < 10; j++) begin
        if (f == 0) vec[j] = int'($urandom_range(0, 255)) - 128;
        else        vec[j] = int'($urandom_range(0, 12)) - 6;
      end
      model10();
      push(1, 10);
      send(1, 10, t_last);
      wait_done(1, t_last, 1'b0);
    end

    repeat (3) @(posedge clk);
    check("sb0_empty", sb0.size(), 0);
    check("sb1_empty", sb1.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
